// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU with single-cycle ops and iterative signed mul/div
// Divider datapath and DIV state are built only when ALU_DIV_EN is defined.
module alu_multicycle #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               r_state;
    logic [SHW-1:0]       r_cnt;
    logic                 r_req;
    logic                 r_in_ready;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [4:0]           r_op;
    logic [SHW-1:0]       r_sh;
    // r_mcand: multiplicand or divisor magnitude; r_prod: {acc, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic                 r_ne;
    logic                 r_lt;
    logic                 r_ovf;
    logic                 r_exc;

    logic                 w_in_long;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_add_ovf;
    logic                 w_sub_ovf;
    logic                 w_ne;
    logic                 w_lt;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_neg;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_sprod;
    logic [WIDTH:0]       w_mul_top;
    logic                 w_mul_ovf;
    logic [WIDTH-1:0]     w_sc_result;
    logic                 w_sc_ovf;
    logic                 w_sc_exc;
    logic                 w_sc_flags;

`ifdef ALU_DIV_EN
    logic                 w_b_zero;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_trial;
    logic [WIDTH-1:0]     w_squo;
    logic                 w_div_ovf;

    assign w_in_long   = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);
    assign w_b_zero    = (r_b == '0);
    assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_mcand};
    assign w_squo      = w_neg ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    // Only MIN / -1 yields a positive quotient with the top bit set
    assign w_div_ovf   = !w_neg && r_prod[WIDTH-1];
`else
    assign w_in_long   = (ctrl_ALUopcode == OP_MUL);
`endif

    assign w_sum     = r_a + r_b;
    assign w_diff    = r_a - r_b;
    assign w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
    assign w_ne      = |w_diff;
    assign w_lt      = w_diff[WIDTH-1] ^ w_sub_ovf;
    assign w_abs_a   = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_abs_b   = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_neg     = r_a[WIDTH-1] ^ r_b[WIDTH-1];

    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_sprod   = w_neg ? -r_prod : r_prod;
    assign w_mul_top = w_sprod[2*WIDTH-1:WIDTH-1];
    assign w_mul_ovf = !((&w_mul_top) || !(|w_mul_top));

    always_comb begin
        w_sc_result = '0;
        w_sc_ovf    = 1'b0;
        w_sc_exc    = 1'b0;
        w_sc_flags  = 1'b1;
        case (r_op)
            OP_ADD: begin
                w_sc_result = w_sum;
                w_sc_ovf    = w_add_ovf;
            end
            OP_SUB: begin
                w_sc_result = w_diff;
                w_sc_ovf    = w_sub_ovf;
            end
            OP_AND: w_sc_result = r_a & r_b;
            OP_OR:  w_sc_result = r_a | r_b;
            OP_SLL: w_sc_result = r_a << r_sh;
            OP_SRA: w_sc_result = $signed(r_a) >>> r_sh;
            OP_DIV: w_sc_exc    = 1'b1;
            default: w_sc_flags = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_sh        <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ne        <= 1'b0;
            r_lt        <= 1'b0;
            r_ovf       <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_req       <= 1'b0;
            if (in_valid && r_in_ready) begin
                r_req      <= 1'b1;
                r_a        <= data_operandA;
                r_b        <= data_operandB;
                r_op       <= ctrl_ALUopcode;
                r_sh       <= ctrl_shiftamt;
                r_in_ready <= !w_in_long;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_req) begin
                        if (r_op == OP_MUL) begin
                            r_state <= S_MUL;
                            r_cnt   <= '0;
                            r_mcand <= w_abs_a;
                            r_prod  <= {{WIDTH{1'b0}}, w_abs_b};
                        end
`ifdef ALU_DIV_EN
                        else if (r_op == OP_DIV) begin
                            r_cnt <= '0;
                            if (w_b_zero) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_DIV;
                                r_mcand <= w_abs_b;
                                r_prod  <= {{WIDTH{1'b0}}, w_abs_a};
                            end
                        end
`endif
                        else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_sc_result;
                            r_ne        <= w_sc_flags & w_ne;
                            r_lt        <= w_sc_flags & w_lt;
                            r_ovf       <= w_sc_ovf;
                            r_exc       <= w_sc_exc;
                        end
                    end
                end
                S_MUL: begin
                    r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    if (!w_div_trial[WIDTH]) begin
                        r_prod <= {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
                    end else begin
                        r_prod <= {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                    r_ne        <= w_ne;
                    r_lt        <= w_lt;
                    if (r_op == OP_MUL) begin
                        r_result <= w_sprod[WIDTH-1:0];
                        r_ovf    <= w_mul_ovf;
                        r_exc    <= 1'b0;
                    end
`ifdef ALU_DIV_EN
                    else if (w_b_zero) begin
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_exc    <= 1'b1;
                    end else begin
                        r_result <= w_squo;
                        r_ovf    <= w_div_ovf;
                        r_exc    <= 1'b0;
                    end
`else
                    else begin
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_exc    <= 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign data_result = r_result;
    assign isNotEqual  = r_ne;
    assign isLessThan  = r_lt;
    assign overflow    = r_ovf;
    assign exception   = r_exc;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle
// Expectations for opcode 7 follow ALU_DIV_EN.
module tb_alu_multicycle;

    localparam int W = 32;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;
    localparam logic [4:0] OP_RSV = 5'd12;

`ifdef ALU_DIV_EN
    localparam int          DIV_LAT  = W + 2;
    localparam int          DIV0_LAT = 2;
    localparam logic [31:0] DA_RES = 32'hFFFFFFFD;
    localparam logic [3:0]  DA_FLG = 4'b1100;
    localparam logic [31:0] DB_RES = 32'h80000000;
    localparam logic [3:0]  DB_FLG = 4'b1110;
    localparam logic [31:0] DC_RES = 32'd3;
    localparam logic [3:0]  DC_FLG = 4'b1000;
`else
    localparam int          DIV_LAT  = 1;
    localparam int          DIV0_LAT = 1;
    localparam logic [31:0] DA_RES = 32'h0;
    localparam logic [3:0]  DA_FLG = 4'b1101;
    localparam logic [31:0] DB_RES = 32'h0;
    localparam logic [3:0]  DB_FLG = 4'b1101;
    localparam logic [31:0] DC_RES = 32'h0;
    localparam logic [3:0]  DC_FLG = 4'b1001;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_operandA;
    logic [W-1:0]  data_operandB;
    logic [4:0]    ctrl_ALUopcode;
    logic [4:0]    ctrl_shiftamt;
    logic          out_valid;
    logic [W-1:0]  data_result;
    logic          isNotEqual;
    logic          isLessThan;
    logic          overflow;
    logic          exception;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alu_multicycle #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .out_valid      (out_valid),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .exception      (exception)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        in_valid       = 1'b1;
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
    endtask

    // Issues one request and returns cycles from accept edge to out_valid (-1 on timeout)
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat);
        @(negedge clock);
        drive(op, a, b, sh);
        @(posedge clock);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic expect_op(input string tag, input int lat, input int exp_lat,
                             input logic [31:0] exp_res, input logic [3:0] exp_flg);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, data_result, exp_res);
        check({tag, "_flags"}, {isNotEqual, isLessThan, overflow, exception}, exp_flg);
    endtask

    int lat;
    int mul_lat, add_lat, acc_edge, nv, ir_bad;
    logic pending;
    logic [31:0] mul_res, add_res;
    logic [3:0]  mul_flg;

    initial begin
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        data_operandA  = '0;
        data_operandB  = '0;
        ctrl_ALUopcode = '0;
        ctrl_shiftamt  = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", data_result, 0);
        check("rst_flags", {isNotEqual, isLessThan, overflow, exception}, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back add then sub
        @(negedge clock);
        drive(OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
        @(posedge clock);
        #1 drive(OP_SUB, 32'h80000000, 32'h1, 5'd0);
        @(posedge clock);
        #1 in_valid = 1'b0;
        check("b2b_add_valid", out_valid, 1);
        check("b2b_add_res", data_result, 32'h80000000);
        check("b2b_add_flags", {isNotEqual, isLessThan, overflow, exception}, 4'b1010);
        @(posedge clock);
        #1;
        check("b2b_sub_valid", out_valid, 1);
        check("b2b_sub_res", data_result, 32'h7FFFFFFF);
        check("b2b_sub_flags", {isNotEqual, isLessThan, overflow, exception}, 4'b1110);
        @(posedge clock);
        #1;
        check("b2b_pulse_end", out_valid, 0);

        // mul -7*6 with an add held behind it
        @(negedge clock);
        drive(OP_MUL, 32'hFFFFFFF9, 32'd6, 5'd0);
        @(posedge clock);
        #1 drive(OP_ADD, 32'd10, 32'd20, 5'd0);
        pending = 1'b0; ir_bad = 0; nv = 0;
        mul_lat = -1; add_lat = -1; acc_edge = -1;
        mul_res = '0; add_res = '0; mul_flg = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (pending) begin
                in_valid = 1'b0;
                acc_edge = c;
                pending  = 1'b0;
            end
            if (out_valid) begin
                nv++;
                if (mul_lat < 0) begin
                    mul_lat = c;
                    mul_res = data_result;
                    mul_flg = {isNotEqual, isLessThan, overflow, exception};
                end else begin
                    add_lat = c;
                    add_res = data_result;
                end
            end
            if (c < W + 2 && in_ready) ir_bad++;
            if (in_valid && in_ready) pending = 1'b1;
        end
        in_valid = 1'b0;
        check("mul_lat", 64'(mul_lat), 64'(W + 2));
        check("mul_res", mul_res, 32'hFFFFFFD6);
        check("mul_flags", mul_flg, 4'b1100);
        check("mul_busy_ready", 64'(ir_bad), 0);
        check("held_after_mul", 64'(acc_edge > mul_lat), 1);
        check("held_add_lat", 64'(add_lat), 64'(acc_edge + 1));
        check("held_add_res", add_res, 32'd30);
        check("valid_pulses", 64'(nv), 2);

        run_op(OP_MUL, 32'h00010000, 32'h00010000, 5'd0, lat);
        expect_op("mul_ovf", lat, W + 2, 32'h0, 4'b0010);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd0, lat);
        expect_op("div_neg", lat, DIV_LAT, DA_RES, DA_FLG);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, lat);
        expect_op("div_min", lat, DIV_LAT, DB_RES, DB_FLG);
        run_op(OP_DIV, 32'd9, 32'd3, 5'd0, lat);
        expect_op("div_9_3", lat, DIV_LAT, DC_RES, DC_FLG);
        run_op(OP_DIV, 32'd5, 32'd0, 5'd0, lat);
        expect_op("div_zero", lat, DIV0_LAT, 32'h0, 4'b1001);

        run_op(OP_RSV, 32'd5, 32'd9, 5'd3, lat);
        expect_op("reserved", lat, 1, 32'h0, 4'b0000);
        run_op(OP_SLL, 32'd1, 32'd0, 5'd31, lat);
        expect_op("sll31", lat, 1, 32'h80000000, 4'b1000);
        run_op(OP_SRA, 32'h80000000, 32'd0, 5'd4, lat);
        expect_op("sra4", lat, 1, 32'hF8000000, 4'b1100);
        run_op(OP_SRA, 32'h80000001, 32'h80000001, 5'd0, lat);
        expect_op("sra0", lat, 1, 32'h80000001, 4'b0000);

        // Reset in the middle of a multiply
        @(negedge clock);
        drive(OP_MUL, 32'd5, 32'd3, 5'd0);
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_result", data_result, 0);
        check("midrst_flags", {isNotEqual, isLessThan, overflow, exception}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (out_valid) nv++;
        end
        check("midrst_no_valid", 64'(nv), 0);
        run_op(OP_ADD, 32'd3, 32'd4, 5'd0, lat);
        expect_op("post_rst_add", lat, 1, 32'd7, 4'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
